// File: rtl/moore_seq_detector_p.sv
// ---------------------------------------------------------------------------
// moore_seq_detector_p
// Runtime-programmable Moore serial sequence detector. The pattern, its
// length (1..MAX_LEN) and the overlap mode are loaded through cfg_load. The
// state is the number of pattern-prefix bits currently matched. The next
// state follows the KMP failure rule.
//
// Optional feature macro: MOORE_MATCH_COUNT_EN
//   defined   -> saturating match counter, cnt_clr and count_sat are built
//   undefined -> match_count and count_sat are tied low, cnt_clr is ignored
// ---------------------------------------------------------------------------
module moore_seq_detector_p #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               match,
  output logic [LEN_W-1:0]   state_o,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  // Clamp a requested length into 1..MAX_LEN.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw);
    logic [LEN_W-1:0] res;
    if (raw == {LEN_W{1'b0}}) begin
      res = LEN_W'(1'b1);
    end else if (raw > LEN_W'(MAX_LEN)) begin
      res = LEN_W'(MAX_LEN);
    end else begin
      res = raw;
    end
    return res;
  endfunction

  // Longest k <= min(sp+1, len) such that the last k bits of
  // w = pat[0..sp-1], bit_in equal pat[0..k-1]. Later (larger) hits in the
  // ascending loop override smaller ones, which is the same as a priority
  // search from the top down.
  function automatic logic [LEN_W-1:0] kmp_next(
    input logic [MAX_LEN-1:0] pat,
    input logic [LEN_W-1:0]   len,
    input logic [LEN_W-1:0]   sp,
    input logic               bit_in
  );
    logic [MAX_LEN:0] pat_ext;
    logic [MAX_LEN:0] w_vec;
    logic [MAX_LEN:0] mask_k;
    logic [MAX_LEN:0] suffix;
    logic [LEN_W-1:0] kmax;
    logic [LEN_W-1:0] k_v;
    logic [LEN_W-1:0] best;
    pat_ext = {1'b0, pat};
    // Bits of the pattern below sp, with the new bit placed at position sp.
    w_vec   = (pat_ext & ~({(MAX_LEN+1){1'b1}} << sp))
            | ({{MAX_LEN{1'b0}}, bit_in} << sp);
    kmax    = ((sp + LEN_W'(1'b1)) > len) ? len : (sp + LEN_W'(1'b1));
    best    = {LEN_W{1'b0}};
    for (int k = 1; k <= MAX_LEN; k++) begin
      k_v    = LEN_W'(k);
      mask_k = ~({(MAX_LEN+1){1'b1}} << k_v);
      suffix = (w_vec >> (sp + LEN_W'(1'b1) - k_v)) & mask_k;
      if ((k_v <= kmax) && (suffix == (pat_ext & mask_k))) begin
        best = k_v;
      end else begin
        best = best;
      end
    end
    return best;
  endfunction

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [LEN_W-1:0]   state_q, state_d;
  logic               match_q, match_d;
  logic [LEN_W-1:0]   start_s;
  logic               accept_s;
  logic               hit_s;

  // A sample is consumed only when no configuration load competes with it.
  assign accept_s = en & ~cfg_load;

  // Effective prefix length before the new bit: restart from zero after a
  // full match when overlapping matches are disabled.
  always_comb begin
    start_s = state_q;
    if ((state_q == len_q) && !overlap_q) begin
      start_s = {LEN_W{1'b0}};
    end else begin
      start_s = state_q;
    end
  end

  // Next configuration, next state and next Moore output.
  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    state_d   = state_q;
    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = clamp_len(cfg_len);
      overlap_d = cfg_overlap;
      state_d   = {LEN_W{1'b0}};
    end else if (en) begin
      state_d   = kmp_next(pattern_q, len_q, start_s, din);
    end else begin
      state_d   = state_q;
    end
    match_d = (state_d == len_d);
  end

  // A completed pattern on an accepted sample bumps the counter.
  assign hit_s = accept_s && (state_d == len_q);

  // Detector state and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q <= {MAX_LEN{1'b0}};
      len_q     <= LEN_W'(1'b1);
      overlap_q <= 1'b1;
      state_q   <= {LEN_W{1'b0}};
      match_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      state_q   <= state_d;
      match_q   <= match_d;
    end
  end

  assign match   = match_q;
  assign state_o = state_q;

`ifdef MOORE_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  // Saturating match counter; a load or an explicit clear wins over a hit.
  always_comb begin
    count_d = count_q;
    if (cfg_load) begin
      count_d = {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (hit_s && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1'b1);
    end else begin
      count_d = count_q;
    end
    sat_d = (count_d == CNT_MAX);
  end

  // Counter and saturation flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign match_count = count_q;
  assign count_sat   = sat_q;
`else
  logic unused_cnt_s;

  // Counter not built: outputs are constant and the unused inputs are sunk.
  assign unused_cnt_s = cnt_clr ^ hit_s;
  assign match_count  = {CNT_W{1'b0}};
  assign count_sat    = 1'b0;
`endif

endmodule
